// File: rtl/regfile_wb.sv
// regfile_wb -- result write-back queue in front of the register file.
//
// Accepted results (single, pair, pair-with-R15) are queued in a DEPTH-entry
// FIFO and drained one entry per cycle into the register-file write port
// whenever the port is free. Decode operand numbers are checked against all
// queued writes to flag read-after-write hazards.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   res_valid / res_ready       result handshake (transfer when both are 1)
//   res_type                    00 invalid, 01 single, 10 pair, 11 pair-with-R15
//   res_rd1/2, res_data1/2      destination registers and data
//   wb_hold                     write port busy, no pop this cycle
//   rWrite, wop1/2, wdata1/2,
//   r15data                     register-file write port (from queue head)
//   rd_op1/2 -> hit1/2          operand hazard against queued writes
//   count                       number of queued entries
//   type_err                    sticky flag: a res_type=00 transfer occurred
//
// Optional macro REGFILE_WB_FWD_EN adds fwd_data1/fwd_data2: data of the
// youngest queued write matching rd_op1/rd_op2 (0 when no hit).

module regfile_wb #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [1:0]               res_type,
  input  logic [3:0]               res_rd1,
  input  logic [3:0]               res_rd2,
  input  logic [15:0]              res_data1,
  input  logic [15:0]              res_data2,
  input  logic                     wb_hold,
  output logic [1:0]               rWrite,
  output logic [3:0]               wop1,
  output logic [3:0]               wop2,
  output logic [15:0]              wdata1,
  output logic [15:0]              wdata2,
  output logic [15:0]              r15data,
  input  logic [3:0]               rd_op1,
  input  logic [3:0]               rd_op2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     type_err
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic [15:0]              fwd_data1,
  output logic [15:0]              fwd_data2
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RT_NONE   = 2'b00,
    RT_SINGLE = 2'b01,
    RT_PAIR   = 2'b10,
    RT_PAIR15 = 2'b11
  } res_type_t;

  res_type_t      q_type  [DEPTH];
  logic [3:0]     q_rd1   [DEPTH];
  logic [3:0]     q_rd2   [DEPTH];
  logic [15:0]    q_data1 [DEPTH];
  logic [15:0]    q_data2 [DEPTH];

  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic           xfer;
  logic           push;
  logic           pop;

  // Ready depends only on occupancy, so a full queue never accepts even when
  // the head leaves on the same edge.
  assign res_ready = !reset && (count < FULL);
  assign xfer      = res_valid && res_ready;
  assign push      = xfer && (res_type_t'(res_type) != RT_NONE);
  assign pop       = !reset && (count != '0) && !wb_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      type_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer && (res_type_t'(res_type) == RT_NONE)) type_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_type[wptr]  <= res_type_t'(res_type);
      q_rd1[wptr]   <= res_rd1;
      q_rd2[wptr]   <= res_rd2;
      q_data1[wptr] <= res_data1;
      q_data2[wptr] <= res_data2;
    end
  end

  always_comb begin
    rWrite  = 2'b00;
    wop1    = '0;
    wop2    = '0;
    wdata1  = '0;
    wdata2  = '0;
    r15data = '0;
    if (pop) begin
      wop1   = q_rd1[rptr];
      wdata1 = q_data1[rptr];
      case (q_type[rptr])
        RT_SINGLE: rWrite = 2'b01;
        RT_PAIR: begin
          rWrite = 2'b10;
          wop2   = q_rd2[rptr];
          wdata2 = q_data2[rptr];
        end
        RT_PAIR15: begin
          rWrite  = 2'b11;
          r15data = q_data2[rptr];
        end
        default: rWrite = 2'b00;
      endcase
    end
  end

  function automatic logic entry_hit(input logic [3:0] op, input res_type_t t,
                                     input logic [3:0] r1, input logic [3:0] r2);
    return (op == r1) || ((t == RT_PAIR) && (op == r2)) ||
           ((t == RT_PAIR15) && (op == 4'hF));
  endfunction

`ifdef REGFILE_WB_FWD_EN
  // Within one entry the second write (rd2 or R15) is taken as the later one.
  function automatic logic [15:0] entry_data(input logic [3:0] op, input res_type_t t,
                                             input logic [3:0] r1, input logic [3:0] r2,
                                             input logic [15:0] d1, input logic [15:0] d2);
    logic [15:0] d;
    d = '0;
    if (op == r1) d = d1;
    if ((t == RT_PAIR) && (op == r2)) d = d2;
    if ((t == RT_PAIR15) && (op == 4'hF)) d = d2;
    return d;
  endfunction
`endif

  // Walk valid entries oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
`ifdef REGFILE_WB_FWD_EN
    fwd_data1 = '0;
    fwd_data2 = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (!reset && ((PW+1)'(k) < count)) begin
        if (entry_hit(rd_op1, q_type[idx], q_rd1[idx], q_rd2[idx])) begin
          hit1 = 1'b1;
`ifdef REGFILE_WB_FWD_EN
          fwd_data1 = entry_data(rd_op1, q_type[idx], q_rd1[idx], q_rd2[idx],
                                 q_data1[idx], q_data2[idx]);
`endif
        end
        if (entry_hit(rd_op2, q_type[idx], q_rd1[idx], q_rd2[idx])) begin
          hit2 = 1'b1;
`ifdef REGFILE_WB_FWD_EN
          fwd_data2 = entry_data(rd_op2, q_type[idx], q_rd1[idx], q_rd2[idx],
                                 q_data1[idx], q_data2[idx]);
`endif
        end
      end
    end
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-queue entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports res_valid input 1, res_ready output 1: result handshake; transfer on edge where both are 1.
REQ-005 SHALL have port res_type  input  2  00 invalid, 01 single, 10 pair, 11 pair-with-R15.
REQ-006 SHALL have ports res_rd1, res_rd2  input  4 each  destination register numbers.
REQ-007 SHALL have ports res_data1, res_data2  input  16 each  result data.
REQ-008 SHALL have port wb_hold  input  1  1 = write port unavailable; no pop this cycle.
REQ-009 SHALL have ports rWrite output 2; wop1, wop2 output 4; wdata1, wdata2, r15data output 16: register-file write port.
REQ-010 SHALL have ports rd_op1, rd_op2  input  4  decode read operands, for hazard check.
REQ-011 SHALL have ports hit1, hit2  output  1  operand matches a pending queued write.
REQ-012 SHALL have ports count output $clog2(DEPTH)+1 and type_err output 1 (sticky).

Function
REQ-013 SHALL hold accepted results in a DEPTH-entry FIFO with type, rd1, rd2, data1, data2 per entry.
REQ-014 SHALL drive res_ready = !reset && (count < DEPTH); no push-through when full, even if a pop occurs.
REQ-015 SHALL drive write-port outputs combinationally from the FIFO head; empty or wb_hold=1 -> rWrite=00, all other write outputs 0.
REQ-016 SHALL map head type to rWrite: single -> 01 (wop1/wdata1); pair -> 10 (wop1/wdata1 and wop2/wdata2); pair-with-R15 -> 11 (wop1/wdata1 and r15data=data2, wop2=0, wdata2=0).
REQ-017 SHALL pop the head on every edge where count>0 and wb_hold=0.
REQ-018 SHALL give minimum latency one cycle: result accepted at edge k into an empty queue is presented during cycle k..k+1 and written at edge k+1.
REQ-019 SHALL keep count unchanged on a simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-020 SHALL accept res_type=00 transfers but not queue them, setting type_err=1 until reset.
REQ-021 SHALL assert hitN when rd_opN equals rd1 of any valid entry, rd2 of any valid pair entry, or 4'hF for any valid pair-with-R15 entry; incoming (not yet accepted) results are excluded.
REQ-022 SHALL preserve strict FIFO order; writes are never merged or reordered.

Reset
REQ-023 SHALL on an edge with reset=1 clear pointers, count=0, type_err=0; pending entries are discarded and never written.
REQ-024 SHALL ignore res_valid and wb_hold on a reset edge; res_ready=0, rWrite=00, hit1=hit2=0 while reset=1.

Configuration
REQ-025 SHALL, with macro REGFILE_WB_FWD_EN defined, add outputs fwd_data1, fwd_data2 (16 each) carrying the data of the youngest valid entry matching rd_op1/rd_op2 (pair-with-R15 supplies data2 for R15), 0 when no hit.
REQ-026 SHALL, without REGFILE_WB_FWD_EN, omit fwd_data1/fwd_data2 entirely; all other behaviour identical.

Verification
REQ-027 SHALL cover: reset, push single rd1=3 data1=16'hAFAF, wb_hold=0 -> next cycle rWrite=01, wop1=3, wdata1=AFAF; then rWrite=00, count=0.
REQ-028 SHALL cover: wb_hold=1, push pair(A,EEEE;B,0110), single(C,AAAA), pair-R15(D,0331;5555), single(1,1111) -> res_ready=0, count=4; release hold -> rWrite 10,01,11,01 on four consecutive cycles in order.
REQ-029 SHALL cover: queue holds pair-R15 rd1=D, rd_op1=F, rd_op2=D -> hit1=1, hit2=1; rd_op1=E -> hit1=0; with REGFILE_WB_FWD_EN fwd_data1=5555.
REQ-030 SHALL cover: res_type=00 push -> count unchanged, type_err=1, persists through 10 cycles until reset.
REQ-031 SHALL cover: count=3, wb_hold=1, push via reset asserted same edge -> count=0, no write issued after reset deasserts.
REQ-032 SHALL cover: full queue, wb_hold=0, res_valid=1 -> no accept that edge, pop occurs, accept next edge; 20-push wrap run with DEPTH=4 matches scoreboard order.
